// File: rtl/shift_serializer_pkg.sv
// Shared definitions for the shift serializer: FSM state encoding and
// helpers that size the divider and bit counters from the block parameters.
package shift_serializer_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_e;

    // Divider counts 0..CLK_DIV-1; keep at least one bit when CLK_DIV is 1.
    function automatic int div_cnt_w(input int clk_div);
        return (clk_div <= 1) ? 1 : $clog2(clk_div);
    endfunction

    // Bit counter must hold BIT_WIDTH itself, not just BIT_WIDTH-1.
    function automatic int bit_cnt_w(input int bit_width);
        return $clog2(bit_width + 1);
    endfunction

endpackage

// File: rtl/ser_tick_gen.sv
// Half-period divider for sclk: phase is the registered sclk level, tick
// marks the last clk cycle of the current half-period.
module ser_tick_gen
    import shift_serializer_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic phase,
    output logic tick
);

    localparam int CW = div_cnt_w(CLK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;

    assign tick  = enable && (cnt_q == CNT_MAX);
    assign phase = phase_q;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (clear) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (enable) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/shift_serializer.sv
// Parallel-to-serial driver for an external shift-register chain: shifts one
// frame out on sdata/sclk, then strobes latch and pulses done.
module shift_serializer
    import shift_serializer_pkg::*;
#(
    parameter int BIT_WIDTH = 16,
    parameter int CLK_DIV   = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [BIT_WIDTH-1:0] par_in,
    output logic                 sdata,
    output logic                 sclk,
    output logic                 latch,
    output logic                 busy,
    output logic                 done,
    output logic [STATE_W-1:0]   dbg_state
);

    localparam int BCW = bit_cnt_w(BIT_WIDTH);
    localparam logic [BCW-1:0] BITS = BCW'(BIT_WIDTH);

    state_e               state_q, state_d;
    logic [BIT_WIDTH-1:0] shreg_q, shreg_d;
    logic [BCW-1:0]       bitcnt_q, bitcnt_d;
    logic                 sdata_q, sdata_d;
    logic                 latch_q, latch_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic phase, tick, gen_clear, gen_enable, last_shift;

    function automatic logic out_bit(input logic [BIT_WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? v[BIT_WIDTH-1] : v[0];
    endfunction

    function automatic logic [BIT_WIDTH-1:0] shifted(input logic [BIT_WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? {v[BIT_WIDTH-2:0], 1'b0} : {1'b0, v[BIT_WIDTH-1:1]};
    endfunction

    // The divider is held cleared outside SHIFT/LATCH and re-cleared on every
    // state exit, so sclk (the divider phase flop) is low whenever not shifting.
    assign gen_enable = (state_q != ST_IDLE);
    assign last_shift = (state_q == ST_SHIFT) && tick && phase && (bitcnt_q == BCW'(1));
    assign gen_clear  = (state_q == ST_IDLE) || abort || last_shift ||
                        ((state_q == ST_LATCH) && tick);

    ser_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (gen_clear),
        .enable(gen_enable),
        .phase (phase),
        .tick  (tick)
    );

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        sdata_d  = sdata_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_SHIFT;
                    shreg_d  = par_in;
                    bitcnt_d = BITS;
                    sdata_d  = out_bit(par_in);
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (tick && phase) begin
                    shreg_d  = shifted(shreg_q);
                    bitcnt_d = bitcnt_q - 1'b1;
                    // Keep the final bit on sdata through LATCH and IDLE.
                    if (bitcnt_q == BCW'(1)) begin
                        state_d = ST_LATCH;
                    end else begin
                        sdata_d = out_bit(shreg_d);
                    end
                end
            end
            ST_LATCH: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        latch_d = (state_d == ST_LATCH);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            sdata_q  <= 1'b0;
            latch_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            sdata_q  <= sdata_d;
            latch_q  <= latch_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign sdata     = sdata_q;
    assign sclk      = phase;
    assign latch     = latch_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_shift_serializer.sv
// Bench for shift_serializer: an MSB-first and an LSB-first instance share
// stimulus; bits seen at sclk rising edges are compared with the frame data.
module tb_shift_serializer;
    import shift_serializer_pkg::*;

    localparam int BW    = 8;
    localparam int CD    = 2;
    localparam int LAT   = 2 * CD * BW + CD;
    localparam int LIMIT = 2 * LAT + 50;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [BW-1:0] par_in = '0;

    logic sdata_m, sclk_m, latch_m, busy_m, done_m;
    logic sdata_l, sclk_l, latch_l, busy_l, done_l;
    logic [STATE_W-1:0] dbg_m, dbg_l;

    int checks = 0;
    int passed = 0;

    logic q_m[$];
    logic q_l[$];
    logic exp_q_m[$];
    logic exp_q_l[$];
    logic prev_m = 1'b0;
    logic prev_l = 1'b0;
    int   lcnt_m = 0;
    int   lcnt_l = 0;

    shift_serializer #(.BIT_WIDTH(BW), .CLK_DIV(CD), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .par_in(par_in),
        .sdata(sdata_m), .sclk(sclk_m), .latch(latch_m), .busy(busy_m),
        .done(done_m), .dbg_state(dbg_m)
    );

    shift_serializer #(.BIT_WIDTH(BW), .CLK_DIV(CD), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .par_in(par_in),
        .sdata(sdata_l), .sclk(sclk_l), .latch(latch_l), .busy(busy_l),
        .done(done_l), .dbg_state(dbg_l)
    );

    always #5 clk = ~clk;

    // Observe the chain interface the way the external shift register would.
    always @(negedge clk) begin
        if (sclk_m && !prev_m) q_m.push_back(sdata_m);
        if (sclk_l && !prev_l) q_l.push_back(sdata_l);
        prev_m = sclk_m;
        prev_l = sclk_l;
        if (latch_m) lcnt_m++;
        if (latch_l) lcnt_l++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] pack_q(input logic q[$]);
        logic [63:0] w = '0;
        for (int i = 0; i < q.size() && i < 64; i++) w[i] = q[i];
        return w;
    endfunction

    task automatic kick(input logic [BW-1:0] d);
        start  = 1'b1;
        par_in = d;
    endtask

    // Expects start/par_in already driven at a negedge; the next edge accepts.
    task automatic frame(input logic [BW-1:0] d, input int inj_at, input int abort_at,
                         input int rst_at, input bit chain, input logic [BW-1:0] nd);
        int n;
        int dn;
        bit seen;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        q_m.delete();
        q_l.delete();
        lcnt_m = 0;
        lcnt_l = 0;
        check("accept_busy_sclk", {busy_m, busy_l, sclk_m, sclk_l}, 4'b1100);
        check("accept_state", dbg_m, ST_SHIFT);
        n = 0;
        seen = 1'b0;
        while (!seen && n < LIMIT) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == inj_at) begin
                start  = 1'b1;
                par_in = 8'hFF;
            end else if (inj_at > 0 && n == inj_at + 1) begin
                start = 1'b0;
            end
            if (n == abort_at) begin
                abort = 1'b1;
                @(posedge clk);
                @(negedge clk);
                abort = 1'b0;
                check("abort_outputs", {busy_m, sclk_m, latch_m, busy_l, sclk_l, latch_l}, 6'b0);
                check("abort_state", dbg_m, ST_IDLE);
                check("abort_bits_sent", q_m.size(), 4);
                dn = 0;
                repeat (40) begin
                    @(negedge clk);
                    dn += int'(done_m) + int'(done_l);
                end
                check("abort_no_done", dn, 0);
                return;
            end
            if (n == rst_at) begin
                check("latch_before_rst", {latch_m, latch_l}, 2'b11);
                rst_n = 1'b0;
                #1;
                check("rst_async_m", {sdata_m, sclk_m, latch_m, busy_m, done_m}, 5'b0);
                check("rst_async_l", {sdata_l, sclk_l, latch_l, busy_l, done_l}, 5'b0);
                check("rst_async_state", {dbg_m, dbg_l}, {ST_IDLE, ST_IDLE});
                @(negedge clk);
                check("rst_no_done", {done_m, done_l, busy_m, busy_l}, 4'b0);
                rst_n = 1'b1;
                return;
            end
            if (done_m) seen = 1'b1;
        end
        check("done_seen", seen, 1'b1);
        check("done_latency", n, LAT);
        check("done_lsb_same_cycle", done_l, 1'b1);
        exp_q_m.delete();
        exp_q_l.delete();
        for (int i = BW - 1; i >= 0; i--) exp_q_m.push_back(d[i]);
        for (int i = 0; i < BW; i++) exp_q_l.push_back(d[i]);
        check("bit_count_msb", q_m.size(), exp_q_m.size());
        check("bit_count_lsb", q_l.size(), exp_q_l.size());
        check("bits_msb", pack_q(q_m), pack_q(exp_q_m));
        check("bits_lsb", pack_q(q_l), pack_q(exp_q_l));
        check("latch_cycles", {lcnt_m[7:0], lcnt_l[7:0]}, {8'(CD), 8'(CD)});
        if (chain) begin
            kick(nd);
        end else begin
            @(negedge clk);
            check("idle_after_done", {busy_m, busy_l, done_m, done_l, sclk_m, latch_m}, 6'b0);
        end
    endtask

    initial begin
        logic [BW-1:0] r;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs_m", {sdata_m, sclk_m, latch_m, busy_m, done_m}, 5'b0);
        check("reset_outputs_l", {sdata_l, sclk_l, latch_l, busy_l, done_l}, 5'b0);
        check("reset_state", {dbg_m, dbg_l}, {ST_IDLE, ST_IDLE});
        rst_n = 1'b1;
        @(negedge clk);

        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        check("abort_in_idle", {busy_m, busy_l, sclk_m, done_m}, 4'b0);

        kick(8'hA5); frame(8'hA5, 0, 0, 0, 1'b0, 8'h00);
        @(negedge clk);
        kick(8'h01); frame(8'h01, 0, 0, 0, 1'b0, 8'h00);
        @(negedge clk);
        kick(8'hA5); frame(8'hA5, 10, 0, 0, 1'b0, 8'h00);
        @(negedge clk);
        kick(8'hA5); frame(8'hA5, 0, 0, 0, 1'b1, 8'h3C);
        frame(8'h3C, 0, 0, 0, 1'b0, 8'h00);

        repeat (4) begin
            @(negedge clk);
            r = 8'($urandom_range(0, 255));
            kick(r); frame(r, 0, 0, 0, 1'b0, 8'h00);
        end

        @(negedge clk);
        kick(8'hA5); frame(8'hA5, 0, 17, 0, 1'b0, 8'h00);
        r = 8'($urandom_range(0, 255));
        kick(r); frame(r, 0, 0, 0, 1'b0, 8'h00);

        @(negedge clk);
        kick(8'h5A); frame(8'h5A, 0, 0, 32, 1'b0, 8'h00);
        kick(8'h81); frame(8'h81, 0, 0, 0, 1'b0, 8'h00);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
